odyssey_video_timing: RTL and testbench



---
 rtl/odyssey_video_timing.sv | 84 ++++++++
 tb/tb_odyssey_video_timing.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/odyssey_video_timing.sv
// odyssey_video_timing: Odyssey raster counters with sync/blank decodes for the MiSTer emu wrapper
// Ports: clk system clock; reset_n async active-low reset; ce count enable; pal requested mode (1 = PAL),
//        taken only at frame end; hcnt/vcnt raster position; hsync/vsync active-high sync; hblank/vblank
//        blanking; line_start/frame_start one-clock strobes; pal_active mode of the current frame.
module odyssey_video_timing #(
  parameter logic [10:0] H_TOTAL_NTSC  = 11'd1270,
  parameter logic [10:0] H_TOTAL_PAL   = 11'd1280,
  parameter logic [8:0]  V_TOTAL_NTSC  = 9'd262,
  parameter logic [8:0]  V_TOTAL_PAL   = 9'd312,
  parameter logic [10:0] HS_WIDTH      = 11'd94,
  parameter logic [8:0]  VS_WIDTH      = 9'd3,
  parameter logic [10:0] HB_END        = 11'd88,
  parameter logic [10:0] HB_START      = 11'd1147,
  parameter logic [8:0]  VB_END        = 9'd34,
  parameter logic [8:0]  VB_START_NTSC = 9'd240,
  parameter logic [8:0]  VB_START_PAL  = 9'd290
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        pal,
  output logic [10:0] hcnt,
  output logic [8:0]  vcnt,
  output logic        hsync,
  output logic        vsync,
  output logic        hblank,
  output logic        vblank,
  output logic        line_start,
  output logic        frame_start,
  output logic        pal_active
);
  logic [10:0] r_hcnt, w_htot, w_htot_n, w_hcnt_n;
  logic [8:0]  r_vcnt, w_vtot, w_vtot_n, w_vbs_n, w_vcnt_n;
  logic        r_pal, w_pal_n, w_hend, w_fend;
  logic        r_hsync, r_vsync, r_hblank, r_vblank, r_line_start, r_frame_start;
  // Wrap uses the current frame's totals; decodes use the totals of the frame the next position belongs to.
  always_comb begin
    w_htot   = r_pal ? H_TOTAL_PAL : H_TOTAL_NTSC;
    w_vtot   = r_pal ? V_TOTAL_PAL : V_TOTAL_NTSC;
    w_hend   = r_hcnt == w_htot - 11'd1;
    w_fend   = w_hend && (r_vcnt == w_vtot - 9'd1);
    w_hcnt_n = w_hend ? 11'd0 : r_hcnt + 11'd1;
    w_vcnt_n = w_fend ? 9'd0 : w_hend ? r_vcnt + 9'd1 : r_vcnt;
    w_pal_n  = w_fend ? pal : r_pal;
    w_htot_n = w_pal_n ? H_TOTAL_PAL : H_TOTAL_NTSC;
    w_vtot_n = w_pal_n ? V_TOTAL_PAL : V_TOTAL_NTSC;
    w_vbs_n  = w_pal_n ? VB_START_PAL : VB_START_NTSC;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hcnt        <= 11'd0;
      r_vcnt        <= 9'd0;
      r_pal         <= 1'b0;
      r_hsync       <= 1'b0;
      r_vsync       <= 1'b0;
      r_hblank      <= 1'b1;
      r_vblank      <= 1'b1;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (ce) begin
      r_hcnt        <= w_hcnt_n;
      r_vcnt        <= w_vcnt_n;
      r_pal         <= w_pal_n;
      r_hsync       <= w_hcnt_n >= w_htot_n - HS_WIDTH;
      r_vsync       <= w_vcnt_n >= w_vtot_n - VS_WIDTH;
      r_hblank      <= !(w_hcnt_n >= HB_END && w_hcnt_n < HB_START);
      r_vblank      <= !(w_vcnt_n >= VB_END && w_vcnt_n < w_vbs_n);
      r_line_start  <= w_hcnt_n == 11'd0;
      r_frame_start <= w_hcnt_n == 11'd0 && w_vcnt_n == 9'd0;
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end
  assign hcnt        = r_hcnt;
  assign vcnt        = r_vcnt;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign hblank      = r_hblank;
  assign vblank      = r_vblank;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign pal_active  = r_pal;
endmodule

// File: tb/tb_odyssey_video_timing.sv
// tb_odyssey_video_timing: random-stimulus checks of a scaled raster instance plus a default-size instance
module tb_odyssey_video_timing;
  logic clk = 1'b0, reset_n, ce, pal;
  logic [10:0] hcnt0, hcnt1;
  logic [8:0]  vcnt0, vcnt1;
  logic hs0, vs0, hb0, vb0, ls0, fs0, pa0;
  logic hs1, vs1, hb1, vb1, ls1, fs1, pa1;
  logic [26:0] v0, v1;
  int total = 0, bad = 0;
  int mn[2];
  bit mp[2], mls[2], mfs[2];
  localparam logic [26:0] RV = {11'd0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic [26:0] R1 = {11'd1, 9'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  always #5 clk = ~clk;
  assign v0 = {hcnt0, vcnt0, hs0, vs0, hb0, vb0, ls0, fs0, pa0};
  assign v1 = {hcnt1, vcnt1, hs1, vs1, hb1, vb1, ls1, fs1, pa1};
  odyssey_video_timing #(
    .H_TOTAL_NTSC(11'd40), .H_TOTAL_PAL(11'd44), .V_TOTAL_NTSC(9'd12), .V_TOTAL_PAL(9'd14),
    .HS_WIDTH(11'd5), .VS_WIDTH(9'd2), .HB_END(11'd4), .HB_START(11'd34),
    .VB_END(9'd2), .VB_START_NTSC(9'd10), .VB_START_PAL(9'd12)
  ) u_small (
    .clk(clk), .reset_n(reset_n), .ce(ce), .pal(pal), .hcnt(hcnt0), .vcnt(vcnt0),
    .hsync(hs0), .vsync(vs0), .hblank(hb0), .vblank(vb0),
    .line_start(ls0), .frame_start(fs0), .pal_active(pa0)
  );
  odyssey_video_timing u_full (
    .clk(clk), .reset_n(reset_n), .ce(ce), .pal(pal), .hcnt(hcnt1), .vcnt(vcnt1),
    .hsync(hs1), .vsync(vs1), .hblank(hb1), .vblank(vb1),
    .line_start(ls1), .frame_start(fs1), .pal_active(pa1)
  );
  function automatic int ht(int s, bit p); return s != 0 ? (p ? 1280 : 1270) : (p ? 44 : 40); endfunction
  function automatic int vt(int s, bit p); return s != 0 ? (p ? 312 : 262) : (p ? 14 : 12); endfunction
  function automatic int hsw(int s); return s != 0 ? 94 : 5; endfunction
  function automatic int vsw(int s); return s != 0 ? 3 : 2; endfunction
  function automatic int hbe(int s); return s != 0 ? 88 : 4; endfunction
  function automatic int hbs(int s); return s != 0 ? 1147 : 34; endfunction
  function automatic int vbe(int s); return s != 0 ? 34 : 2; endfunction
  function automatic int vbs(int s, bit p); return s != 0 ? (p ? 290 : 240) : (p ? 12 : 10); endfunction
  // Reference: position is the count of enabled clocks since frame start, split into line and column.
  function automatic logic [26:0] mexp(int s);
    int h, v, t, f;
    t = ht(s, mp[s]);
    f = vt(s, mp[s]);
    h = mn[s] % t;
    v = mn[s] / t;
    return {11'(h), 9'(v), h >= t - hsw(s), v >= f - vsw(s), !(h >= hbe(s) && h < hbs(s)),
            !(v >= vbe(s) && v < vbs(s, mp[s])), mls[s], mfs[s], mp[s]};
  endfunction
  task automatic mreset();
    for (int s = 0; s < 2; s++) begin
      mn[s] = 0; mp[s] = 0; mls[s] = 0; mfs[s] = 0;
    end
  endtask
  task automatic tick();
    bit c, p;
    c = ce;
    p = pal;
    @(posedge clk);
    if (!reset_n) mreset();
    else for (int s = 0; s < 2; s++) begin
      if (c) begin
        if (mn[s] == ht(s, mp[s]) * vt(s, mp[s]) - 1) begin mn[s] = 0; mp[s] = p; end
        else mn[s]++;
      end
      mls[s] = c && (mn[s] % ht(s, mp[s]) == 0);
      mfs[s] = c && mn[s] == 0;
    end
    #1;
  endtask
  task automatic test_reset();
    reset_n = 0; ce = 0; pal = 0;
    mreset();
    repeat (3) tick();
    total++; if (v0 !== RV) begin bad++; $display("FAIL reset_small got=%h exp=%h", v0, RV); end
    total++; if (v1 !== RV) begin bad++; $display("FAIL reset_full got=%h exp=%h", v1, RV); end
    ce = 1; reset_n = 1;
    tick();
    total++; if (v0 !== R1) begin bad++; $display("FAIL release_small got=%h exp=%h", v0, R1); end
    total++; if (v1 !== R1) begin bad++; $display("FAIL release_full got=%h exp=%h", v1, R1); end
  endtask
  task automatic test_default_line();
    int hsc = 0, last = -1;
    logic prev = 0;
    for (int i = 0; i < 2600; i++) begin
      tick();
      total++; if (v1 !== mexp(1)) begin bad++; $display("FAIL full_line got=%h exp=%h", v1, mexp(1)); end
      if (hs1 && !prev) begin
        total++; if (hcnt1 !== 11'd1176) begin bad++; $display("FAIL hsync_start got=%0d exp=1176", hcnt1); end
      end
      prev = hs1;
      if (hs1 && vcnt1 == 0) hsc++;
      if (ls1) begin
        if (last >= 0) begin
          total++; if (i - last != 1270) begin bad++; $display("FAIL full_line_period got=%0d exp=1270", i - last); end
        end
        last = i;
      end
    end
    total++; if (hsc != 94) begin bad++; $display("FAIL hsync_width got=%0d exp=94", hsc); end
  endtask
  task automatic test_ntsc_frame();
    int last = -1;
    for (int i = 0; i < 1000; i++) begin
      tick();
      total++; if (v0 !== mexp(0)) begin bad++; $display("FAIL ntsc_frame got=%h exp=%h", v0, mexp(0)); end
      if (fs0) begin
        if (last >= 0) begin
          total++; if (i - last != 480) begin bad++; $display("FAIL ntsc_frame_period got=%0d exp=480", i - last); end
        end
        last = i;
      end
    end
  endtask
  task automatic test_mode_switch();
    int last = -1, i = 0;
    bit fpa = 0, over = 0, sw = 0;
    logic ppa;
    for (i = 0; i < 1000 && vcnt0 != 9'd5; i++) begin
      tick();
      total++; if (v0 !== mexp(0)) begin bad++; $display("FAIL mode_wait got=%h exp=%h", v0, mexp(0)); end
    end
    total++; if (vcnt0 != 9'd5) begin bad++; $display("FAIL mode_wait_timeout got=%0d exp=5", vcnt0); end
    pal = 1;
    ppa = pa0;
    for (i = 0; i < 1400; i++) begin
      tick();
      total++; if (v0 !== mexp(0)) begin bad++; $display("FAIL mode_switch got=%h exp=%h", v0, mexp(0)); end
      if (!pa0 && vcnt0 > 9'd11) over = 1;
      if (pa0 && !ppa) begin
        sw = 1;
        total++; if ({hcnt0, vcnt0, fs0} !== {20'd0, 1'b1}) begin bad++; $display("FAIL switch_point got=%0d,%0d exp=0,0", hcnt0, vcnt0); end
      end
      ppa = pa0;
      if (fs0) begin
        if (last >= 0) begin
          total++; if (i - last != ht(0, fpa) * vt(0, fpa)) begin bad++; $display("FAIL mode_frame_period got=%0d exp=%0d", i - last, ht(0, fpa) * vt(0, fpa)); end
        end
        last = i;
        fpa = pa0;
      end
    end
    total++; if (over || !sw) begin bad++; $display("FAIL mode_bounds got=%0d%0d exp=01", over, sw); end
  endtask
  task automatic test_ce_gating();
    int last = -1;
    for (int i = 0; i < 400; i++) begin
      ce = (i % 2 == 0);
      tick();
      total++; if (v0 !== mexp(0)) begin bad++; $display("FAIL ce_gating got=%h exp=%h", v0, mexp(0)); end
      if (ls0) begin
        if (last >= 0) begin
          total++; if (i - last != 2 * ht(0, pa0)) begin bad++; $display("FAIL ce_line_period got=%0d exp=%0d", i - last, 2 * ht(0, pa0)); end
        end
        last = i;
      end
    end
    ce = 1;
  endtask
  task automatic test_mid_reset();
    int i;
    for (i = 0; i < 2000 && !(pa0 && vcnt0 == 9'd8 && hcnt0 == 11'd20); i++) begin
      tick();
      total++; if (v0 !== mexp(0)) begin bad++; $display("FAIL mid_wait got=%h exp=%h", v0, mexp(0)); end
    end
    total++; if (!(pa0 && vcnt0 == 9'd8 && hcnt0 == 11'd20)) begin bad++; $display("FAIL mid_wait_timeout got=%0d,%0d exp=20,8", hcnt0, vcnt0); end
    #2 reset_n = 0;
    mreset();
    #1;
    total++; if (v0 !== RV) begin bad++; $display("FAIL async_reset_small got=%h exp=%h", v0, RV); end
    total++; if (v1 !== RV) begin bad++; $display("FAIL async_reset_full got=%h exp=%h", v1, RV); end
    tick();
    reset_n = 1;
    tick();
    total++; if (v0 !== R1) begin bad++; $display("FAIL resume got=%h exp=%h", v0, R1); end
    for (i = 0; i < 600; i++) begin
      tick();
      total++; if (v0 !== mexp(0)) begin bad++; $display("FAIL after_reset got=%h exp=%h", v0, mexp(0)); end
    end
  endtask
  task automatic test_back_to_back();
    logic ppa;
    ppa = pa0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) pal = ~pal;
      if ($urandom_range(0, 7) == 0) ce = 0; else ce = 1;
      tick();
      total++; if (v0 !== mexp(0)) begin bad++; $display("FAIL back_to_back got=%h exp=%h", v0, mexp(0)); end
      if (pa0 !== ppa) begin
        total++; if ({hcnt0, vcnt0, pa0} !== {20'd0, pal}) begin bad++; $display("FAIL toggle_point got=%0d,%0d,%0d exp=0,0,%0d", hcnt0, vcnt0, pa0, pal); end
      end
      ppa = pa0;
    end
    ce = 1;
  endtask
  initial begin
    test_reset();
    test_default_line();
    test_ntsc_frame();
    test_mode_switch();
    test_ce_gating();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
